// File: rtl/dac_spi_tx.sv
// dac_spi_tx: Wishbone-fed sample FIFO serialising 16-bit words to an SPI DAC; define DAC_SPI_TX_LDAC_EN to pulse LDAC_N during LATCH.
module dac_spi_tx #(
    parameter int ADDR_WIDTH     = 17,
    parameter int MUX_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                               WB_CLK,
    input  logic                               rst,
    input  logic                               WBS_CYC,
    input  logic                               WBS_STB,
    input  logic                               WBS_WE,
    input  logic                               WBS_RD,
    input  logic [3:0]                         WBS_BYTE_STB,
    input  logic [ADDR_WIDTH-MUX_ADDR_WIDTH-1:0] WBS_ADR,
    input  logic [DATA_WIDTH-1:0]              WBS_WR_DAT,
    output logic [DATA_WIDTH-1:0]              WBS_RD_DAT,
    output logic                               WBS_ACK,
    input  logic                               SIG_UPDATE,
    output logic                               CS_N,
    output logic                               SCLK,
    output logic                               DIN,
    output logic                               LDAC_N,
    output logic                               DAC_BUSY,
    output logic                               DAC_IRQ
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
    state_t state, state_n;
    logic unused;
    logic req, wr, wr_ctrl, wr_stat, wr_data, wr_div, flush;
    logic [5:0] reg_adr;
    logic en, irq_en, sig_q, trig, start, last;
    logic ovf, unf, miss;
    logic [7:0] clkdiv, div_q, hc;
    logic [4:0] ph;
    logic [15:0] sr;
    logic [15:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] level;
    logic empty, full, push, drop;
    logic [DATA_WIDTH-1:0] status, rd_val;
    assign unused  = &{1'b0, WBS_BYTE_STB, WBS_RD, WBS_ADR, WBS_WR_DAT};
    assign reg_adr = WBS_ADR[7:2];
    assign req     = WBS_CYC & WBS_STB & ~WBS_ACK;
    assign wr      = req & WBS_WE;
    assign wr_ctrl = wr & (reg_adr == 6'h00);
    assign wr_stat = wr & (reg_adr == 6'h01);
    assign wr_data = wr & (reg_adr == 6'h02);
    assign wr_div  = wr & (reg_adr == 6'h03);
    assign flush   = wr_ctrl & WBS_WR_DAT[2];
    assign trig    = SIG_UPDATE & ~sig_q & en;
    assign empty   = level == '0;
    assign full    = level == (PW+1)'(FIFO_DEPTH);
    assign start   = trig & (state == IDLE) & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push
    assign push    = wr_data & (~full | start);
    assign drop    = wr_data & full & ~start;
    assign last    = (state == SHIFT) & (hc == div_q) & (ph == 5'd31);
    always_comb begin
        status       = '0;
        status[5:0]  = {miss, unf, ovf, full, empty, DAC_BUSY};
        status[11:8] = 4'(level);
        rd_val = (reg_adr == 6'h01) ? status : (reg_adr == 6'h03) ? DATA_WIDTH'(clkdiv) : '0;
    end
    always_ff @(posedge WB_CLK or negedge rst) begin
        if (!rst) begin
            WBS_ACK    <= 1'b0;
            WBS_RD_DAT <= '0;
            sig_q      <= 1'b0;
            en         <= 1'b0;
            irq_en     <= 1'b0;
            clkdiv     <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            miss       <= 1'b0;
            DAC_IRQ    <= 1'b0;
            wp         <= '0;
            rp         <= '0;
            level      <= '0;
        end else begin
            WBS_ACK    <= req;
            WBS_RD_DAT <= (req & ~WBS_WE) ? rd_val : '0;
            sig_q      <= SIG_UPDATE;
            if (wr_ctrl) {irq_en, en} <= WBS_WR_DAT[1:0];
            if (wr_div) clkdiv <= WBS_WR_DAT[7:0];
            ovf     <= drop | (ovf & ~(wr_stat & WBS_WR_DAT[3]));
            unf     <= (trig & (state == IDLE) & empty) | (unf & ~(wr_stat & WBS_WR_DAT[4]));
            miss    <= (trig & (state != IDLE)) | (miss & ~(wr_stat & WBS_WR_DAT[5]));
            DAC_IRQ <= irq_en & (ovf | unf | miss);
            wp      <= flush ? '0 : wp + PW'(push);
            rp      <= flush ? '0 : rp + PW'(start);
            level   <= flush ? '0 : level + (PW+1)'(push) - (PW+1)'(start);
        end
    end
    always_ff @(posedge WB_CLK) begin
        if (push) mem[wp] <= WBS_WR_DAT[15:0];
    end
    // Each SCLK half-period lasts div_q+1 cycles; ph counts the 32 half-periods
    always_ff @(posedge WB_CLK or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            hc    <= '0;
            ph    <= '0;
            sr    <= '0;
        end else if (start) begin
            div_q <= clkdiv;
            hc    <= '0;
            ph    <= '0;
            sr    <= mem[rp];
        end else if (state == SHIFT) begin
            hc <= (hc == div_q) ? '0 : hc + 8'd1;
            ph <= (hc == div_q) ? ph + 5'd1 : ph;
            sr <= (hc == div_q && ph[0]) ? {sr[14:0], 1'b0} : sr;
        end
    end
    always_ff @(posedge WB_CLK or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE) ? (start ? SHIFT : IDLE) :
                  (state == SHIFT) ? (last ? LATCH : SHIFT) : IDLE;
    end
    always_comb begin
        CS_N     = state != SHIFT;
        SCLK     = (state == SHIFT) & ph[0];
        DIN      = (state == SHIFT) & sr[15];
        DAC_BUSY = state != IDLE;
`ifdef DAC_SPI_TX_LDAC_EN
        LDAC_N   = state != LATCH;
`else
        LDAC_N   = 1'b0;
`endif
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: register table, directed frame corner cases and a randomized FIFO/frame run against a queue model.
module tb_dac_spi_tx;
    logic        WB_CLK = 1'b0;
    logic        rst = 1'b0;
    logic        WBS_CYC = 1'b0, WBS_STB = 1'b0, WBS_WE = 1'b0, WBS_RD = 1'b0;
    logic [3:0]  WBS_BYTE_STB = 4'hF;
    logic [7:0]  WBS_ADR = '0;
    logic [31:0] WBS_WR_DAT = '0;
    logic [31:0] WBS_RD_DAT;
    logic        WBS_ACK;
    logic        SIG_UPDATE = 1'b0;
    logic        CS_N, SCLK, DIN, LDAC_N, DAC_BUSY, DAC_IRQ;
`ifdef DAC_SPI_TX_LDAC_EN
    localparam logic LDAC_IDLE = 1'b1;
`else
    localparam logic LDAC_IDLE = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    logic [15:0] q[$];
    logic m_ovf, m_unf;

    dac_spi_tx dut (
        .WB_CLK(WB_CLK), .rst(rst),
        .WBS_CYC(WBS_CYC), .WBS_STB(WBS_STB), .WBS_WE(WBS_WE), .WBS_RD(WBS_RD),
        .WBS_BYTE_STB(WBS_BYTE_STB), .WBS_ADR(WBS_ADR), .WBS_WR_DAT(WBS_WR_DAT),
        .WBS_RD_DAT(WBS_RD_DAT), .WBS_ACK(WBS_ACK), .SIG_UPDATE(SIG_UPDATE),
        .CS_N(CS_N), .SCLK(SCLK), .DIN(DIN), .LDAC_N(LDAC_N),
        .DAC_BUSY(DAC_BUSY), .DAC_IRQ(DAC_IRQ)
    );

    always #5 WB_CLK = ~WB_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] d, output logic [31:0] r);
        int n = 0;
        WBS_CYC = 1'b1; WBS_STB = 1'b1; WBS_WE = we; WBS_RD = ~we;
        WBS_ADR = adr; WBS_WR_DAT = d;
        do begin
            @(negedge WB_CLK);
            n++;
        end while (!WBS_ACK && n < 8);
        check("ack", {31'b0, WBS_ACK}, 32'd1);
        r = WBS_RD_DAT;
        WBS_CYC = 1'b0; WBS_STB = 1'b0; WBS_WE = 1'b0; WBS_RD = 1'b0;
        @(negedge WB_CLK);
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, adr, d, r);
    endtask

    task automatic wb_chk(input string name, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, adr, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic pulse();
        SIG_UPDATE = 1'b1;
        @(negedge WB_CLK);
        SIG_UPDATE = 1'b0;
    endtask

    // Collects the bits seen on SCLK rising edges and the CS_N low length; optionally retriggers mid-frame
    task automatic capture(input int miss_at, output logic [15:0] w, output int len);
        logic prev = 1'b0;
        w = '0;
        len = 0;
        for (int i = 0; i < 8 && CS_N; i++) @(negedge WB_CLK);
        while (!CS_N && len < 1000) begin
            len++;
            if (SCLK && !prev) w = {w[14:0], DIN};
            prev = SCLK;
            if (len == miss_at) SIG_UPDATE = 1'b1;
            else if (len == miss_at + 1) SIG_UPDATE = 1'b0;
            @(negedge WB_CLK);
        end
        check("latch_busy", {31'b0, DAC_BUSY}, 32'd1);
        check("latch_ldac", {31'b0, LDAC_N}, 32'd0);
        @(negedge WB_CLK);
        check("post_busy", {31'b0, DAC_BUSY}, 32'd0);
        check("post_ldac", {31'b0, LDAC_N}, {31'b0, LDAC_IDLE});
    endtask

    task automatic watch_idle(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (!CS_N || SCLK) lows++;
            @(negedge WB_CLK);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n = q.size();
        return (32'(n) << 8) | (32'(m_unf) << 4) | (32'(m_ovf) << 3) |
               (32'(n == 8) << 2) | (32'(n == 0) << 1);
    endfunction

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[16];

    initial begin
        logic [15:0] w;
        int len, lows;
        vecs[0]  = '{1'b0, 8'h00, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 8'h04, 32'h0, 32'h002};
        vecs[2]  = '{1'b0, 8'h0C, 32'h0, 32'h0};
        vecs[3]  = '{1'b1, 8'h0C, 32'h1A5, 32'h0};
        vecs[4]  = '{1'b0, 8'h0C, 32'h0, 32'hA5};
        vecs[5]  = '{1'b1, 8'h10, 32'hFF, 32'h0};
        vecs[6]  = '{1'b0, 8'h10, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 8'h0C, 32'h0, 32'hA5};
        vecs[8]  = '{1'b1, 8'h08, 32'h1234ABCD, 32'h0};
        vecs[9]  = '{1'b0, 8'h04, 32'h0, 32'h100};
        vecs[10] = '{1'b0, 8'h08, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 8'h00, 32'h4, 32'h0};
        vecs[12] = '{1'b0, 8'h04, 32'h0, 32'h002};
        vecs[13] = '{1'b1, 8'h00, 32'h3, 32'h0};
        vecs[14] = '{1'b0, 8'h00, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 8'h0C, 32'h0, 32'h0};

        repeat (3) @(negedge WB_CLK);
        rst = 1'b1;
        @(negedge WB_CLK);
        check("rst_cs_n", {31'b0, CS_N}, 32'd1);
        check("rst_sclk", {31'b0, SCLK}, 32'd0);
        check("rst_din", {31'b0, DIN}, 32'd0);
        check("rst_busy", {31'b0, DAC_BUSY}, 32'd0);
        check("rst_irq", {31'b0, DAC_IRQ}, 32'd0);
        check("rst_ack", {31'b0, WBS_ACK}, 32'd0);
        check("rst_rd_dat", WBS_RD_DAT, 32'd0);
        check("rst_ldac", {31'b0, LDAC_N}, {31'b0, LDAC_IDLE});

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) wb_wr(vecs[i].adr, vecs[i].wd);
            else wb_chk($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
        end

        // Basic frame, CLKDIV=0
        wb_wr(8'h00, 32'h1);
        wb_wr(8'h08, 32'hABCD);
        pulse();
        capture(-1, w, len);
        check("frame_word", {16'b0, w}, 32'hABCD);
        check("frame_len", 32'(len), 32'd32);
        wb_chk("frame_stat", 8'h04, 32'h002);

        // Overflow and OVF clear
        for (int i = 0; i < 9; i++) wb_wr(8'h08, 32'(i));
        wb_chk("ovf_stat", 8'h04, 32'h80C);
        wb_wr(8'h04, 32'h08);
        wb_chk("ovf_clr", 8'h04, 32'h804);
        wb_wr(8'h00, 32'h5);
        wb_chk("flush_stat", 8'h04, 32'h002);

        // Underflow and interrupt
        wb_wr(8'h00, 32'h3);
        pulse();
        check("irq_early", {31'b0, DAC_IRQ}, 32'd0);
        @(negedge WB_CLK);
        check("irq_set", {31'b0, DAC_IRQ}, 32'd1);
        watch_idle(6, lows);
        check("unf_no_cs", 32'(lows), 32'd0);
        wb_chk("unf_stat", 8'h04, 32'h012);
        wb_wr(8'h04, 32'h38);
        wb_wr(8'h00, 32'h1);

        // Retrigger mid-frame, CLKDIV=3
        wb_wr(8'h0C, 32'h3);
        wb_wr(8'h08, 32'h5A5A);
        pulse();
        capture(20, w, len);
        check("miss_word", {16'b0, w}, 32'h5A5A);
        check("miss_len", 32'(len), 32'd128);
        wb_chk("miss_stat", 8'h04, 32'h022);
        wb_wr(8'h04, 32'h38);

        // Asynchronous reset mid-frame
        wb_wr(8'h08, 32'h1111);
        pulse();
        check("pre_rst_cs", {31'b0, CS_N}, 32'd0);
        repeat (9) @(negedge WB_CLK);
        #2 rst = 1'b0;
        #1;
        check("arst_cs_n", {31'b0, CS_N}, 32'd1);
        check("arst_sclk", {31'b0, SCLK}, 32'd0);
        check("arst_busy", {31'b0, DAC_BUSY}, 32'd0);
        @(negedge WB_CLK);
        rst = 1'b1;
        @(negedge WB_CLK);
        wb_chk("arst_stat", 8'h04, 32'h002);
        wb_chk("arst_div", 8'h0C, 32'h0);

        // Randomized traffic against the queue model
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int it = 0; it < 30; it++) begin
            int div = $urandom_range(0, 3);
            logic en = $urandom_range(0, 4) != 0;
            int n = $urandom_range(0, 4);
            wb_wr(8'h00, {31'b0, en});
            wb_wr(8'h0C, 32'(div));
            for (int k = 0; k < n; k++) begin
                logic [15:0] d = 16'($urandom);
                wb_wr(8'h08, {16'($urandom), d});
                if (q.size() == 8) m_ovf = 1'b1;
                else q.push_back(d);
            end
            wb_chk("rnd_stat", 8'h04, model_status());
            if ($urandom_range(0, 3) != 0) begin
                pulse();
                if (en && q.size() > 0) begin
                    logic [15:0] e = q.pop_front();
                    capture(-1, w, len);
                    check("rnd_word", {16'b0, w}, {16'b0, e});
                    check("rnd_len", 32'(len), 32'(32 * (div + 1)));
                end else begin
                    if (en) m_unf = 1'b1;
                    watch_idle(6, lows);
                    check("rnd_idle", 32'(lows), 32'd0);
                end
            end
            wb_chk("rnd_stat2", 8'h04, model_status());
            wb_wr(8'h04, 32'h38);
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
